// File: rtl/hazard3_operand_bypass_pkg.sv
// Shared widths, x0 constant and operand-select encoding for the operand bypass stage.
package hazard3_operand_bypass_pkg;

  localparam int unsigned N_REGS_DEF = 32;
  localparam int unsigned W_DATA_DEF = 32;
  localparam int unsigned W_ADDR_DEF = $clog2(N_REGS_DEF);

  localparam logic [W_ADDR_DEF-1:0] X0_ADDR = W_ADDR_DEF'(0);

  // Operand source, exposed for waveform/debug visibility
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_WB   = 2'd1,
    SEL_FWD  = 2'd2,
    SEL_RF   = 2'd3
  } op_sel_e;

  // Priority encode the operand source
  function automatic op_sel_e op_sel(input logic is_x0, input logic wb_hit, input logic fwd);
    if (is_x0)       return SEL_ZERO;
    else if (wb_hit) return SEL_WB;
    else if (fwd)    return SEL_FWD;
    else             return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard3_operand_bypass_scoreboard.sv
// Load scoreboard: one busy bit per register, set-over-clear, same-cycle clear suppresses hits.
import hazard3_operand_bypass_pkg::*;

module hazard3_load_scoreboard #(
  parameter int unsigned N_REGS = N_REGS_DEF,
  parameter int unsigned W_ADDR = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_issue,
  input  logic [W_ADDR-1:0] ld_rd,
  input  logic              ld_done,
  input  logic [W_ADDR-1:0] ld_done_rd,
  input  logic [W_ADDR-1:0] raddr1,
  input  logic [W_ADDR-1:0] raddr2,
  output logic              hit1_c,
  output logic              hit2_c
);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;

  // Busy update: clear first so a same-cycle issue wins; x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (ld_done)  busy_d[ld_done_rd] = 1'b0;
    if (ld_issue) busy_d[ld_rd]      = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy register
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Hazard hits; a returning load's wb is caught by same-cycle capture so it does not stall
  always_comb begin
    hit1_c = busy_q[raddr1] & ~(ld_done & (ld_done_rd == raddr1)) & (raddr1 != W_ADDR'(0));
    hit2_c = busy_q[raddr2] & ~(ld_done & (ld_done_rd == raddr2)) & (raddr2 != W_ADDR'(0));
  end

endmodule

// File: rtl/hazard3_operand_bypass.sv
// Operand stage behind the 1W/2R regfile: read-address mux, stale-read capture,
// operand select and load-hazard stall.
// Build option: HAZARD3_OPERAND_BYPASS_WB_FWD_EN adds a combinational writeback
// forward into the operands; otherwise a colliding writeback drops op_valid for a cycle.
import hazard3_operand_bypass_pkg::*;

module hazard3_operand_bypass #(
  parameter int unsigned N_REGS = N_REGS_DEF,
  parameter int unsigned W_DATA = W_DATA_DEF,
  parameter int unsigned W_ADDR = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] dec_raddr1,
  input  logic [W_ADDR-1:0] dec_raddr2,
  input  logic              dec_ren,
  output logic              dec_stall,
  input  logic              x_hold,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  input  logic              ld_issue,
  input  logic [W_ADDR-1:0] ld_rd,
  input  logic              ld_done,
  input  logic [W_ADDR-1:0] ld_done_rd,
  output logic              op_valid,
  output logic [W_DATA-1:0] op_rs1,
  output logic [W_DATA-1:0] op_rs2
);

  logic [W_ADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic              vld_q, vld_d;
  logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [W_DATA-1:0] fdat1_q, fdat1_d, fdat2_q, fdat2_d;
  logic              hit1_c, hit2_c;
  logic              wb_hit1_c, wb_hit2_c;
  op_sel_e           sel1_c, sel2_c;

  hazard3_load_scoreboard #(
    .N_REGS (N_REGS),
    .W_ADDR (W_ADDR)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .ld_done    (ld_done),
    .ld_done_rd (ld_done_rd),
    .raddr1     (dec_raddr1),
    .raddr2     (dec_raddr2),
    .hit1_c     (hit1_c),
    .hit2_c     (hit2_c)
  );

  // Regfile address mux (re-read held operands) and decode stall
  always_comb begin
    rf_raddr1 = x_hold ? rs1_q : dec_raddr1;
    rf_raddr2 = x_hold ? rs2_q : dec_raddr2;
    dec_stall = dec_ren & ~x_hold & (hit1_c | hit2_c);
  end

  // Next state: track read addresses and capture writebacks the regfile read will miss
  always_comb begin
    rs1_d   = rf_raddr1;
    rs2_d   = rf_raddr2;
    vld_d   = x_hold ? vld_q : (dec_ren & ~dec_stall);
    fwd1_d  = wb_wen & (wb_waddr == rf_raddr1) & (rf_raddr1 != W_ADDR'(X0_ADDR));
    fwd2_d  = wb_wen & (wb_waddr == rf_raddr2) & (rf_raddr2 != W_ADDR'(X0_ADDR));
    fdat1_d = fwd1_d ? wb_wdata : fdat1_q;
    fdat2_d = fwd2_d ? wb_wdata : fdat2_q;
  end

  // Operand-stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      vld_q   <= 1'b0;
      fwd1_q  <= 1'b0;
      fwd2_q  <= 1'b0;
      fdat1_q <= '0;
      fdat2_q <= '0;
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      vld_q   <= vld_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
      fdat1_q <= fdat1_d;
      fdat2_q <= fdat2_d;
    end
  end

  // Operand select and valid qualification
  always_comb begin
    wb_hit1_c = wb_wen & (wb_waddr == rs1_q);
    wb_hit2_c = wb_wen & (wb_waddr == rs2_q);
`ifdef HAZARD3_OPERAND_BYPASS_WB_FWD_EN
    sel1_c   = op_sel(rs1_q == W_ADDR'(X0_ADDR), wb_hit1_c, fwd1_q);
    sel2_c   = op_sel(rs2_q == W_ADDR'(X0_ADDR), wb_hit2_c, fwd2_q);
    op_valid = vld_q;
`else
    sel1_c   = op_sel(rs1_q == W_ADDR'(X0_ADDR), 1'b0, fwd1_q);
    sel2_c   = op_sel(rs2_q == W_ADDR'(X0_ADDR), 1'b0, fwd2_q);
    op_valid = vld_q & ~((wb_waddr != W_ADDR'(X0_ADDR)) & (wb_hit1_c | wb_hit2_c));
`endif
    case (sel1_c)
      SEL_ZERO: op_rs1 = '0;
      SEL_WB:   op_rs1 = wb_wdata;
      SEL_FWD:  op_rs1 = fdat1_q;
      default:  op_rs1 = rf_rdata1;
    endcase
    case (sel2_c)
      SEL_ZERO: op_rs2 = '0;
      SEL_WB:   op_rs2 = wb_wdata;
      SEL_FWD:  op_rs2 = fdat2_q;
      default:  op_rs2 = rf_rdata2;
    endcase
  end

endmodule

// File: tb/tb_hazard3_operand_bypass.sv
// Directed bench for hazard3_operand_bypass with a read-before-write, 1-cycle-latency regfile.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_hazard3_operand_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  dec_raddr1, dec_raddr2;
  logic        dec_ren, dec_stall, x_hold;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ld_issue, ld_done;
  logic [4:0]  ld_rd, ld_done_rd;
  logic        op_valid;
  logic [31:0] op_rs1, op_rs2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  // Regfile: registered read of the pre-write contents, x0 hard zero
  always @(posedge clk) begin
    rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : mem[rf_raddr1];
    rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : mem[rf_raddr2];
    if (wb_wen && wb_waddr != 5'd0) mem[wb_waddr] <= wb_wdata;
  end

  hazard3_operand_bypass dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_raddr1 (dec_raddr1),
    .dec_raddr2 (dec_raddr2),
    .dec_ren    (dec_ren),
    .dec_stall  (dec_stall),
    .x_hold     (x_hold),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .ld_done    (ld_done),
    .ld_done_rd (ld_done_rd),
    .op_valid   (op_valid),
    .op_rs1     (op_rs1),
    .op_rs2     (op_rs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wen = en; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic dec(input logic en, input logic [4:0] a1, input logic [4:0] a2);
    dec_ren = en; dec_raddr1 = a1; dec_raddr2 = a2;
  endtask

  initial begin
    rst_n = 1'b0; x_hold = 1'b0;
    dec(1'b0, 5'd0, 5'd0);
    wb(1'b0, 5'd0, 32'd0);
    ld_issue = 1'b0; ld_rd = 5'd0; ld_done = 1'b0; ld_done_rd = 5'd0;
    tick(); tick();
    #1;
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_rs1", op_rs1, 32'd0);
    check("rst_op_rs2", op_rs2, 32'd0);
    check("rst_dec_stall", {31'd0, dec_stall}, 32'd0);
    rst_n = 1'b1;

    // Preload x5, x7, x3 through writeback
    wb(1'b1, 5'd5, 32'h0000_1234); tick();
    wb(1'b1, 5'd7, 32'h0000_1111); tick();
    wb(1'b1, 5'd3, 32'h0000_3333); tick();
    wb(1'b0, 5'd0, 32'd0);

    // Plain read of x5
    dec(1'b1, 5'd5, 5'd0); tick();
    dec(1'b0, 5'd0, 5'd0); #1;
    check("plain_rs1", op_rs1, 32'h0000_1234);
    check("plain_valid", {31'd0, op_valid}, 32'd1);
    tick();

    // Read x5 while wb writes x5: capture path
    dec(1'b1, 5'd5, 5'd0); wb(1'b1, 5'd5, 32'h0000_DEAD); tick();
    dec(1'b0, 5'd0, 5'd0); wb(1'b0, 5'd0, 32'd0); #1;
    check("capture_rs1", op_rs1, 32'h0000_DEAD);
    check("capture_valid", {31'd0, op_valid}, 32'd1);
    tick();

    // Operand cycle for x7 coincides with wb x7
    dec(1'b1, 5'd0, 5'd7); tick();
    dec(1'b0, 5'd0, 5'd0); wb(1'b1, 5'd7, 32'h0000_BEEF); x_hold = 1'b1; #1;
`ifdef HAZARD3_OPERAND_BYPASS_WB_FWD_EN
    check("wbfwd_valid", {31'd0, op_valid}, 32'd1);
    check("wbfwd_rs2", op_rs2, 32'h0000_BEEF);
`else
    check("wbcollide_valid", {31'd0, op_valid}, 32'd0);
`endif
    tick();
    wb(1'b0, 5'd0, 32'd0); x_hold = 1'b0; #1;
    check("wbafter_rs2", op_rs2, 32'h0000_BEEF);
    check("wbafter_valid", {31'd0, op_valid}, 32'd1);
    tick();

    // Load to x3 then decode x3: stall until ld_done
    ld_issue = 1'b1; ld_rd = 5'd3; tick();
    ld_issue = 1'b0; dec(1'b1, 5'd3, 5'd0); #1;
    check("ld_stall_a", {31'd0, dec_stall}, 32'd1);
    tick(); #1;
    check("ld_stall_b", {31'd0, dec_stall}, 32'd1);
    check("ld_stall_bubble", {31'd0, op_valid}, 32'd0);
    tick();
    ld_done = 1'b1; ld_done_rd = 5'd3; wb(1'b1, 5'd3, 32'h0000_CAFE); #1;
    check("ld_done_nostall", {31'd0, dec_stall}, 32'd0);
    tick();
    ld_done = 1'b0; wb(1'b0, 5'd0, 32'd0); #1;
    check("ld_data_rs1", op_rs1, 32'h0000_CAFE);
    check("ld_data_valid", {31'd0, op_valid}, 32'd1);
    check("ld_cleared", {31'd0, dec_stall}, 32'd0);
    tick();

    // Issue and done to x4 in the same cycle: set wins
    dec(1'b0, 5'd0, 5'd0);
    ld_issue = 1'b1; ld_rd = 5'd4; ld_done = 1'b1; ld_done_rd = 5'd4; tick();
    ld_issue = 1'b0; ld_done = 1'b0; dec(1'b1, 5'd0, 5'd4); #1;
    check("set_wins_stall", {31'd0, dec_stall}, 32'd1);

    // x0 reads and wb to x0: zero operands, no stall, no bubble
    dec(1'b1, 5'd0, 5'd0); wb(1'b1, 5'd0, 32'hFFFF_FFFF); #1;
    check("x0_nostall", {31'd0, dec_stall}, 32'd0);
    tick(); #1;
    check("x0_rs1", op_rs1, 32'd0);
    check("x0_rs2", op_rs2, 32'd0);
    check("x0_valid", {31'd0, op_valid}, 32'd1);
    wb(1'b0, 5'd0, 32'd0); dec(1'b0, 5'd0, 5'd0);
    ld_done = 1'b1; ld_done_rd = 5'd4; tick();
    ld_done = 1'b0;

    // Hold x5 for 3 cycles while wb rewrites it
    dec(1'b1, 5'd5, 5'd0); tick();
    dec(1'b0, 5'd0, 5'd0); x_hold = 1'b1; wb(1'b1, 5'd5, 32'h0000_00A1); #1;
`ifdef HAZARD3_OPERAND_BYPASS_WB_FWD_EN
    check("hold1_rs1", op_rs1, 32'h0000_00A1);
`else
    check("hold1_valid", {31'd0, op_valid}, 32'd0);
`endif
    tick();
    wb(1'b1, 5'd5, 32'h0000_00A2); #1;
`ifdef HAZARD3_OPERAND_BYPASS_WB_FWD_EN
    check("hold2_rs1", op_rs1, 32'h0000_00A2);
`else
    check("hold2_rs1", op_rs1, 32'h0000_00A1);
`endif
    tick();
    wb(1'b0, 5'd0, 32'd0); #1;
    check("hold3_rs1", op_rs1, 32'h0000_00A2);
    check("hold3_valid", {31'd0, op_valid}, 32'd1);
    tick();
    x_hold = 1'b0; #1;
    check("release_rs1", op_rs1, 32'h0000_00A2);
    tick();

    // Reset in the middle of an outstanding load
    ld_issue = 1'b1; ld_rd = 5'd6; tick();
    ld_issue = 1'b0; dec(1'b1, 5'd6, 5'd0); #1;
    check("prerst_stall", {31'd0, dec_stall}, 32'd1);
    rst_n = 1'b0; dec(1'b1, 5'd5, 5'd0); tick();
    rst_n = 1'b1; dec(1'b1, 5'd6, 5'd0); #1;
    check("postrst_valid", {31'd0, op_valid}, 32'd0);
    check("postrst_stall", {31'd0, dec_stall}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
